fpga_board_io_cond: RTL and testbench

//  Parametrised board-level input conditioner for the FPGA targets, sitting between raw board

---
 rtl/fpga_board_io_cond.sv | 192 +++++++++++++++++++
 tb/tb_fpga_board_io_cond.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpga_board_io_cond.sv
// fpga_board_io_cond
//   Board-level input conditioner between raw FPGA board pins and the SoC top.
//   Each channel is synchronised, debounced and edge-detected. A stretched
//   active-low SoC reset is generated from the board reset and from selected
//   debounced channels.
//
// Ports
//   ref_clk      in   1     single clock, all logic on its rising edge
//   pad_reset    in   1     synchronous active-high reset
//   in_i         in   N_IN  raw asynchronous board inputs
//   state_o      out  N_IN  debounced level per channel
//   rise_o       out  N_IN  one-cycle pulse when state_o goes 0->1
//   fall_o       out  N_IN  one-cycle pulse when state_o goes 1->0
//   soc_rst_n_o  out  1     registered active-low reset to the SoC
//   rst_req_o    out  1     high while any masked debounced channel is 1

module fpga_board_io_cond #(
    parameter int unsigned     N_IN            = 8,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = 100000,
    parameter logic [N_IN-1:0] INIT_VAL        = '0,
    parameter logic [N_IN-1:0] RST_MASK        = '0,
    parameter int unsigned     RST_HOLD        = 16
) (
    input  logic            ref_clk,
    input  logic            pad_reset,
    input  logic [N_IN-1:0] in_i,
    output logic [N_IN-1:0] state_o,
    output logic [N_IN-1:0] rise_o,
    output logic [N_IN-1:0] fall_o,
    output logic            soc_rst_n_o,
    output logic            rst_req_o
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned     HoldW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RST_HOLD - 1);
    localparam int unsigned     SyncW   = SYNC_STAGES * N_IN;

    // Elaboration-time parameter sanity checks.
    if (N_IN < 1 || N_IN > 32) begin : g_bad_n_in
        $error("N_IN must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("RST_HOLD must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser: stage 0 in the low N_IN bits, last stage in the top bits.
    // ------------------------------------------------------------------
    logic [SyncW-1:0] sync_q;
    logic [SyncW-1:0] sync_d;
    logic [N_IN-1:0]  sync_s;

    assign sync_d = {sync_q[SyncW-N_IN-1:0], in_i};
    assign sync_s = sync_q[SyncW-1 -: N_IN];

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: per-channel stability counter; flip_d marks the cycle a
    // channel accepts its new level.
    // ------------------------------------------------------------------
    logic [N_IN-1:0] state_q, state_d;
    logic [N_IN-1:0] rise_q, rise_d;
    logic [N_IN-1:0] fall_q, fall_d;
    logic [N_IN-1:0] flip_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            differ;
        logic            done;

        assign differ    = sync_s[i] ^ state_q[i];
        assign done      = differ && (cnt_q == CntMax);
        assign flip_d[i] = done;

        // Any sample matching the current level restarts the count, so a
        // glitch shorter than DEBOUNCE_CYCLES never produces an event.
        always_comb begin
            cnt_d = '0;
            if (differ && !done) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        always_ff @(posedge ref_clk) begin
            if (pad_reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        state_d = state_q ^ flip_d;
        rise_d  = flip_d & sync_s;
        fall_d  = flip_d & ~sync_s;
    end

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            state_q <= INIT_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Reset generator. rst_req_q tracks state_q (updated on the same edge);
    // the FSM reacts to it one edge later.
    // ------------------------------------------------------------------
    typedef enum logic {
        StAssert,
        StRun
    } rst_state_e;

    rst_state_e       rst_state_q, rst_state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             rst_req_q, rst_req_d;
    logic             soc_rst_n_q, soc_rst_n_d;

    assign rst_req_d = |(state_d & RST_MASK);

    always_comb begin
        rst_state_d = rst_state_q;
        hold_d      = hold_q;
        unique case (rst_state_q)
            StAssert: begin
                if (rst_req_q) begin
                    hold_d = HoldMax;
                end else if (hold_q == '0) begin
                    rst_state_d = StRun;
                    hold_d      = HoldMax;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            StRun: begin
                if (rst_req_q) begin
                    rst_state_d = StAssert;
                    hold_d      = HoldMax;
                end
            end
            default: begin
                rst_state_d = StAssert;
                hold_d      = HoldMax;
            end
        endcase
    end

    assign soc_rst_n_d = (rst_state_d == StRun);

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            rst_state_q <= StAssert;
            hold_q      <= HoldMax;
            rst_req_q   <= 1'b0;
            soc_rst_n_q <= 1'b0;
        end else begin
            rst_state_q <= rst_state_d;
            hold_q      <= hold_d;
            rst_req_q   <= rst_req_d;
            soc_rst_n_q <= soc_rst_n_d;
        end
    end

    assign state_o     = state_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign soc_rst_n_o = soc_rst_n_q;
    assign rst_req_o   = rst_req_q;

endmodule

// File: tb/tb_fpga_board_io_cond.sv
// Testbench for fpga_board_io_cond: directed stimulus pushes hand-computed
// expected output events into a queue; a negedge monitor pops one entry each
// time the DUT shows a pulse or a change on soc_rst_n_o / rst_req_o.

module tb_fpga_board_io_cond;

    localparam int unsigned NIn = 4;

    logic           clk       = 1'b0;
    logic           pad_reset = 1'b1;
    logic [NIn-1:0] in_i      = '0;
    logic [NIn-1:0] state_o;
    logic [NIn-1:0] rise_o;
    logic [NIn-1:0] fall_o;
    logic           soc_rst_n_o;
    logic           rst_req_o;

    fpga_board_io_cond #(
        .N_IN            (NIn),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (5),
        .INIT_VAL        (4'b0000),
        .RST_MASK        (4'b1000),
        .RST_HOLD        (16)
    ) dut (
        .ref_clk     (clk),
        .pad_reset   (pad_reset),
        .in_i        (in_i),
        .state_o     (state_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .soc_rst_n_o (soc_rst_n_o),
        .rst_req_o   (rst_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [NIn-1:0] rise;
        logic [NIn-1:0] fall;
        logic [NIn-1:0] state;
        logic           req;
        logic           soc;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    logic prev_soc = 1'b0;
    logic prev_req = 1'b0;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [NIn-1:0] r, input logic [NIn-1:0] f,
                                 input logic [NIn-1:0] s, input logic q, input logic n);
        ev_t e;
        e.cyc   = c;
        e.rise  = r;
        e.fall  = f;
        e.state = s;
        e.req   = q;
        e.soc   = n;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every visible output event consumes one expected entry.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (((rise_o | fall_o) != '0) || (soc_rst_n_o !== prev_soc) ||
                       (rst_req_o !== prev_req))) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cyc=%0d rise=%b fall=%b state=%b req=%b soc=%b",
                         cyc, rise_o, fall_o, state_o, rst_req_o, soc_rst_n_o);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rise !== rise_o || e.fall !== fall_o ||
                    e.state !== state_o || e.req !== rst_req_o || e.soc !== soc_rst_n_o) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d rise=%b fall=%b state=%b req=%b soc=%b, expected cyc=%0d rise=%b fall=%b state=%b req=%b soc=%b",
                             cyc, rise_o, fall_o, state_o, rst_req_o, soc_rst_n_o,
                             e.cyc, e.rise, e.fall, e.state, e.req, e.soc);
                end
            end
        end
        prev_soc = soc_rst_n_o;
        prev_req = rst_req_o;
    end

    initial begin
        int k;

        // Reset state.
        step(3);
        chk("reset_state", int'(state_o), 0);
        chk("reset_rise_fall", int'({rise_o, fall_o}), 0);
        chk("reset_soc_rst_n", int'(soc_rst_n_o), 0);
        chk("reset_rst_req", int'(rst_req_o), 0);
        mon_en = 1'b1;

        // Reset release: last reset edge is k, SoC reset lifts 16 edges later.
        k = cyc;
        pad_reset = 1'b0;
        push(k + 16, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(10);
        chk("soc_low_during_hold", int'(soc_rst_n_o), 0);
        step(10);

        // Clean press and release on channel 1: latency 2 + 5 = 7.
        k = cyc;
        in_i = 4'b0010;
        push(k + 7, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1);
        step(12);
        in_i = 4'b0000;
        push(k + 19, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1);
        step(18);

        // Bounce on channel 0: 4 high, 1 low, 10 high.
        k = cyc;
        in_i = 4'b0001;
        step(4);
        in_i = 4'b0000;
        step(1);
        in_i = 4'b0001;
        push(k + 12, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1);
        step(10);
        in_i = 4'b0000;
        push(k + 22, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1);
        step(15);

        // Masked channel 3 high for 20 cycles.
        k = cyc;
        in_i = 4'b1000;
        push(k + 7,  4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1);
        push(k + 8,  4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0);
        push(k + 27, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        push(k + 43, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(20);
        in_i = 4'b0000;
        step(30);

        // Simultaneous step on channels 1 and 2.
        k = cyc;
        in_i = 4'b0110;
        push(k + 7, 4'b0110, 4'b0000, 4'b0110, 1'b0, 1'b1);
        step(10);
        in_i = 4'b0000;
        push(k + 17, 4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b1);
        step(15);

        // Abort: pad_reset pulsed mid-debounce on channel 0.
        k = cyc;
        in_i = 4'b0001;
        step(4);
        pad_reset = 1'b1;
        in_i = 4'b0000;
        push(k + 5,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        push(k + 21, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(1);
        pad_reset = 1'b0;
        chk("abort_state_init", int'(state_o), 0);
        step(4);
        chk("abort_no_event_state", int'(state_o), 0);
        step(25);

        chk("pending_expected_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
